// File: rtl/jtframe_sig_pkg.sv
// Shared types, constants and the CRC-32 step function for the frame-signature block.
package jtframe_sig_pkg;

  localparam int unsigned CRC_W = 32;
  localparam logic [CRC_W-1:0] CRC_FINAL_XOR = 32'hFFFF_FFFF;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t SYNC   = 2'd0;
  localparam state_t ACTIVE = 2'd1;
  localparam state_t DONE   = 2'd2;

  // Non-reflected CRC update over the low 'width' bits of data, MSB first.
  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] crc,
    input logic [CRC_W-1:0] data,
    input logic [CRC_W-1:0] poly,
    input int unsigned      width
  );
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = CRC_W - 1; i >= 0; i--) begin
      if (i < int'(width)) begin
        fb = c[CRC_W-1] ^ data[i];
        c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/jtframe_frame_sig_geom.sv
// Per-frame line geometry: pixel/line counters, first-line width capture, sticky length error.
module jtframe_frame_sig_geom #(
  parameter int unsigned CNTW = 10
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            pix,
  input  logic            close,
  output logic [CNTW-1:0] line_cnt,
  output logic [CNTW-1:0] line_w,
  output logic            geom_err
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] pix_cnt;

  // close and pix are mutually exclusive: a pixel needs both blanks low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      line_w   <= '0;
      geom_err <= 1'b0;
    end else if (start) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      line_w   <= '0;
    end else if (close && pix_cnt != '0) begin
      if (line_cnt != CNT_MAX) line_cnt <= line_cnt + CNTW'(1);
      if (line_cnt == '0) line_w <= pix_cnt;
      else if (pix_cnt != line_w) geom_err <= 1'b1;
      pix_cnt <= '0;
    end else if (pix && pix_cnt != CNT_MAX) begin
      pix_cnt <= pix_cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/jtframe_frame_sig.sv
// Frame signature: CRC-32 of every active frame plus geometry and frame count.
// Optional exp_crc comparison enabled by defining JTFRAME_FRAME_SIG_CMP_EN.
module jtframe_frame_sig
  import jtframe_sig_pkg::*;
#(
  parameter int unsigned COLORW   = 4,
  parameter logic [31:0] POLY     = 32'h04C1_1DB7,
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF,
  parameter int unsigned CNTW     = 10,
  parameter int unsigned SKIP     = 0
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic              pxl_hb,
  input  logic              pxl_vb,
  input  logic [COLORW-1:0] red,
  input  logic [COLORW-1:0] green,
  input  logic [COLORW-1:0] blue,
  input  logic [31:0]       exp_crc,
  output logic [31:0]       frame_cnt,
  output logic [31:0]       crc,
  output logic              crc_valid,
  output logic [CNTW-1:0]   width,
  output logic [CNTW-1:0]   height,
  output logic              geom_err,
  output logic              mismatch
);

  localparam int unsigned PXW = 3 * COLORW;

  state_t          state, state_nx;
  logic            hb_r, vb_r;
  logic            hb_rise, vb_rise, vb_fall;
  logic            start_c, pix_c, close_c;
  logic            fin, skip_done, sig_ok;
  logic [31:0]     crc_reg;
  logic [PXW-1:0]  pxl_word;
  logic [CNTW-1:0] line_cnt, line_w;

  assign pxl_word = {red, green, blue};
  assign hb_rise  = pxl_cen &  pxl_hb & ~hb_r;
  assign vb_rise  = pxl_cen &  pxl_vb & ~vb_r;
  assign vb_fall  = pxl_cen & ~pxl_vb &  vb_r;
  assign sig_ok   = skip_done | (({1'b0, frame_cnt} + 33'd1) > 33'(SKIP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    pix_c    = 1'b0;
    close_c  = 1'b0;
    case (state)
      SYNC: begin
        if (vb_fall) begin
          start_c  = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        pix_c   = pxl_cen & ~pxl_hb & ~pxl_vb;
        close_c = hb_rise | vb_rise;
        if (vb_rise) state_nx = DONE;
      end
      DONE:    state_nx = SYNC;
      default: state_nx = SYNC;
    endcase
  end

  // blanking history only advances with the pixel clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_r <= 1'b0;
      vb_r <= 1'b0;
    end else if (pxl_cen) begin
      hb_r <= pxl_hb;
      vb_r <= pxl_vb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       crc_reg <= CRC_INIT;
    else if (start_c) crc_reg <= CRC_INIT;
    else if (pix_c)   crc_reg <= crc_step(crc_reg, 32'(pxl_word), POLY, PXW);
  end

  jtframe_frame_sig_geom #(.CNTW(CNTW)) u_geom (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .pix      (pix_c),
    .close    (close_c),
    .line_cnt (line_cnt),
    .line_w   (line_w),
    .geom_err (geom_err)
  );

  // DONE arms fin, which publishes results one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin       <= 1'b0;
      skip_done <= 1'b0;
      crc_valid <= 1'b0;
      crc       <= '0;
      width     <= '0;
      height    <= '0;
      frame_cnt <= '0;
    end else begin
      fin       <= (state == DONE);
      crc_valid <= 1'b0;
      if (fin) begin
        crc       <= crc_reg ^ CRC_FINAL_XOR;
        width     <= line_w;
        height    <= line_cnt;
        frame_cnt <= frame_cnt + 32'd1;
        if (sig_ok) begin
          crc_valid <= 1'b1;
          skip_done <= 1'b1;
        end
      end
    end
  end

`ifdef JTFRAME_FRAME_SIG_CMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch <= 1'b0;
    else if (fin && sig_ok && ((crc_reg ^ CRC_FINAL_XOR) != exp_crc)) mismatch <= 1'b1;
  end
`else
  logic unused_exp;
  assign unused_exp = ^exp_crc;
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_frame_sig.sv
// Randomised bench for jtframe_frame_sig with a frame-level reference model.
module tb_jtframe_frame_sig;

  localparam int unsigned COLORW = 4;
  localparam int unsigned CNTW   = 10;
  localparam int unsigned SKIP   = 1;
  localparam int unsigned PXW    = 3 * COLORW;
  localparam logic [31:0] POLY   = 32'h04C1_1DB7;

  logic              clk = 1'b0;
  logic              rst_n, pxl_cen, pxl_hb, pxl_vb;
  logic [COLORW-1:0] red, green, blue;
  logic [31:0]       exp_crc, frame_cnt, crc;
  logic              crc_valid, geom_err, mismatch;
  logic [CNTW-1:0]   width, height;

  always #5 clk = ~clk;

  jtframe_frame_sig #(
    .COLORW(COLORW), .POLY(POLY), .CRC_INIT(32'hFFFF_FFFF), .CNTW(CNTW), .SKIP(SKIP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl_hb(pxl_hb), .pxl_vb(pxl_vb),
    .red(red), .green(green), .blue(blue), .exp_crc(exp_crc),
    .frame_cnt(frame_cnt), .crc(crc), .crc_valid(crc_valid),
    .width(width), .height(height), .geom_err(geom_err), .mismatch(mismatch)
  );

  typedef struct {
    int          at;
    logic [31:0] crc;
    int          w;
    int          h;
    bit          valid;
    logic [31:0] exp;
  } ev_t;

  ev_t         ev_q[$];
  int          n_checks = 0, n_errors = 0, cyc = 0, n_valid = 0, cur_div = 1;
  bit          chk_en = 0;
  bit          armed, pvb, phb, e_geom, e_mis;
  logic [31:0] run_crc, e_crc, e_fcnt, last_valid_crc, ref_crc, zero_crc;
  int          cur_len, nlines, first_len, nframes, e_w, e_h;

  // Word-at-a-time CRC-32 (non-reflected), no final xor
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] word, input int w);
    logic [31:0] r;
    r = c ^ (word << (32 - w));
    for (int i = 0; i < w; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model, advanced once per sampled pixel clock
  task automatic model_cen(input bit hb, input bit vb, input logic [PXW-1:0] px);
    bit  vrise, vfall, hrise;
    ev_t ev;
    vrise = vb && !pvb;
    vfall = !vb && pvb;
    hrise = hb && !phb;
    if (armed) begin
      if (!hb && !vb) begin
        run_crc = crc_word(run_crc, 32'(px), PXW);
        cur_len++;
      end
      if ((hrise || vrise) && cur_len > 0) begin
        if (nlines == 0) first_len = cur_len;
        else if (cur_len != first_len) e_geom = 1;
        nlines++;
        cur_len = 0;
      end
      if (vrise) begin
        ev.at    = cyc + 2;
        ev.crc   = run_crc ^ 32'hFFFF_FFFF;
        ev.w     = first_len;
        ev.h     = nlines;
        ev.valid = (nframes >= int'(SKIP));
        ev.exp   = exp_crc;
        ev_q.push_back(ev);
        nframes++;
        armed = 0;
      end
    end else if (vfall) begin
      armed = 1; run_crc = 32'hFFFF_FFFF; cur_len = 0; nlines = 0; first_len = 0;
    end
    pvb = vb;
    phb = hb;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : cmp
    bit  ev_valid;
    ev_t ev;
    if (chk_en) begin
      ev_valid = 0;
      if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        ev       = ev_q.pop_front();
        e_crc    = ev.crc;
        e_w      = ev.w;
        e_h      = ev.h;
        e_fcnt   = e_fcnt + 32'd1;
        ev_valid = ev.valid;
`ifdef JTFRAME_FRAME_SIG_CMP_EN
        if (ev.valid && ev.crc != ev.exp) e_mis = 1;
`endif
      end
      check("crc_valid", 32'(crc_valid), 32'(ev_valid));
      check("crc", crc, e_crc);
      check("frame_cnt", frame_cnt, e_fcnt);
      check("width", 32'(width), 32'(e_w));
      check("height", 32'(height), 32'(e_h));
      check("geom_err", 32'(geom_err), 32'(e_geom));
      check("mismatch", 32'(mismatch), 32'(e_mis));
      if (crc_valid) begin
        n_valid++;
        last_valid_crc = crc;
      end
    end
  end

  task automatic step(input bit cen, input bit hb, input bit vb, input logic [PXW-1:0] px);
    pxl_cen = cen; pxl_hb = hb; pxl_vb = vb;
    {red, green, blue} = px;
    @(posedge clk);
    cyc++;
    if (rst_n && cen) model_cen(hb, vb, px);
    @(negedge clk);
    #1;
  endtask

  // One sampled pixel clock followed by cur_div-1 idle clocks carrying junk
  task automatic pc(input bit hb, input bit vb, input logic [PXW-1:0] px);
    step(1'b1, hb, vb, px);
    repeat (cur_div - 1) step(1'b0, 1'($urandom), 1'($urandom), PXW'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    chk_en = 1;
    armed = 0; pvb = 0; phb = 0; nframes = 0; n_valid = 0;
    ev_q.delete();
    e_crc = '0; e_fcnt = '0; e_w = 0; e_h = 0; e_geom = 0; e_mis = 0;
    repeat (n) step(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
  endtask

  // close_mode: 0 hb rises before vb, 1 vb rises on an open line, 2 both rise together
  task automatic send_frame(input int w, input int h, input int div, input bit rnd,
                            input int bad_line, input int bad_len, input int close_mode);
    cur_div = div;
    repeat (3) pc(1'b1, 1'b1, '0);
    pc(1'b1, 1'b0, '0);
    for (int l = 0; l < h; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : w;
      for (int p = 0; p < len; p++) pc(1'b0, 1'b0, rnd ? PXW'($urandom) : '0);
      if (l != h - 1 || close_mode == 0) repeat (2) pc(1'b1, 1'b0, '0);
    end
    if (h == 0) repeat (2) pc(1'b1, 1'b0, '0);
    pc((close_mode == 1 && h > 0) ? 1'b0 : 1'b1, 1'b1, '0);
    repeat (2) pc(1'b1, 1'b1, '0);
    repeat (2) step(1'b0, 1'b1, 1'b1, '0);
  endtask

  initial begin
    logic [71:0] msg;
    logic [31:0] c;
    rst_n = 1'b1; pxl_cen = 0; pxl_hb = 0; pxl_vb = 0;
    red = '0; green = '0; blue = '0; exp_crc = '0;
    #1;

    // Pin the model against the CRC-32/BZIP2 check value
    msg = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_word(c, 32'(msg[8*(8-i) +: 8]), 8);
    check("model_check_value", c ^ 32'hFFFF_FFFF, 32'hFC89_1918);
    zero_crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) zero_crc = crc_word(zero_crc, 32'd0, PXW);
    zero_crc = zero_crc ^ 32'hFFFF_FFFF;
    exp_crc = zero_crc;

    do_reset(4);

    // Reset in the middle of an active frame
    cur_div = 1;
    repeat (3) pc(1'b1, 1'b1, '0);
    pc(1'b1, 1'b0, '0);
    repeat (2) begin
      repeat (8) pc(1'b0, 1'b0, PXW'($urandom));
      repeat (2) pc(1'b1, 1'b0, '0);
    end
    do_reset(3);
    repeat (8) pc(1'b0, 1'b0, PXW'($urandom));
    repeat (2) pc(1'b1, 1'b0, '0);
    pc(1'b1, 1'b1, '0);
    repeat (4) pc(1'b1, 1'b1, '0);
    check("partial_no_valid", 32'(n_valid), 32'd0);
    check("partial_no_frame", frame_cnt, 32'd0);

    // 8x4 all-zero frame, repeated; first one skipped
    send_frame(8, 4, 1, 1'b0, -1, 0, 0);
    check("a1_frame_cnt", frame_cnt, 32'd1);
    check("a1_width", 32'(width), 32'd8);
    check("a1_height", 32'(height), 32'd4);
    check("a1_crc_model", crc, zero_crc);
    check("a1_no_valid", 32'(n_valid), 32'd0);
    ref_crc = crc;
    send_frame(8, 4, 1, 1'b0, -1, 0, 0);
    send_frame(8, 4, 1, 1'b0, -1, 0, 0);
    check("a3_frame_cnt", frame_cnt, 32'd3);
    check("a3_valid_pulses", 32'(n_valid), 32'd2);
    check("a3_crc_same", last_valid_crc, ref_crc);

    // Pixel enable every 4th clock
    send_frame(8, 4, 4, 1'b0, -1, 0, 0);
    check("cen4_crc_same", crc, ref_crc);
    check("cen4_valid_pulses", 32'(n_valid), 32'd3);

`ifdef JTFRAME_FRAME_SIG_CMP_EN
    send_frame(8, 4, 1, 1'b0, -1, 0, 0);
    check("cmp_match", 32'(mismatch), 32'd0);
    exp_crc = ref_crc ^ 32'd1;
    send_frame(8, 4, 1, 1'b0, -1, 0, 0);
    check("cmp_flip", 32'(mismatch), 32'd1);
`endif

    // Short third line
    send_frame(8, 4, 1, 1'b1, 2, 7, 0);
    check("bad_geom_err", 32'(geom_err), 32'd1);
    check("bad_width", 32'(width), 32'd8);
    send_frame(8, 4, 1, 1'b1, -1, 0, 1);
    check("geom_err_sticky", 32'(geom_err), 32'd1);

    // Frame without active pixels
    send_frame(6, 0, 1, 1'b1, -1, 0, 0);
    check("empty_crc", crc, 32'd0);
    check("empty_width", 32'(width), 32'd0);
    check("empty_height", 32'(height), 32'd0);

    // Random geometry, timing and content
    do_reset(3);
    repeat (12) begin
      int w, h;
      w = int'($urandom_range(1, 12));
      h = int'($urandom_range(0, 5));
      send_frame(w, h, int'($urandom_range(1, 3)), 1'b1,
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 5)) : -1,
                 int'($urandom_range(1, 14)), int'($urandom_range(0, 2)));
    end
    check("rand_frame_cnt", frame_cnt, 32'd12);
    check("rand_valid_pulses", 32'(n_valid), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
